dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder for the single-cycle core's dmem port (dmem_we/addr/wdata -> rdata).
//  Holds a word-addressed RAM plus a small MMIO block: free-running cycle counter, GPIO output
//  register, timer-compare interrupt, write counter and misaligned-write error flag.
//  Sits beside the core at top level; the core sees zero-wait-state reads and writes.
// PARAMETERS
//  ADDR_W     8             word-address bits of RAM (depth = 2**ADDR_W words)
//  MMIO_BASE  32'hFFFF_0000 first byte address of the MMIO region (64 KiB region)
// PORTS
//  clk          in   1   clock, all state updates on rising edge
//  rst          in   1   asynchronous, active-low reset
//  dmem_we      in   1   write enable for the current cycle
//  dmem_addr    in   32  byte address
//  dmem_wdata   in   32  write data
//  dmem_rdata   out  32  read data, combinational from dmem_addr
//  gpio_out     out  32  GPIO register value
//  irq          out  1   timer interrupt pending (STATUS[0])
//  misalign_err out  1   sticky misaligned-write flag (STATUS[1])
// BEHAVIOUR
//  Decode: addr >= MMIO_BASE -> MMIO; else RAM word index = addr[ADDR_W+1:2] (upper bits alias).
//  Reads: combinational, no latency; return state BEFORE the current edge's write (no bypass).
//   Read ignores addr[1:0] (aligned word returned). Reads never change state.
//  Writes: take effect at the rising edge when dmem_we=1 and addr[1:0]==0.
//   dmem_we=1 with addr[1:0]!=0: write suppressed everywhere, STATUS[1] set at that edge.
//  MMIO map (offset from MMIO_BASE):
//   0x00 CYCLE  RO; +1 every cycle, wraps FFFF_FFFF->0; writes ignored.
//   0x04 GPIO   RW; drives gpio_out.
//   0x08 CMP    RW; timer compare value.
//   0x0C STATUS [0]=irq pending, [1]=misalign; write-1-to-clear per bit; [31:2] read 0.
//   0x10 WCOUNT RO; count of accepted RAM writes, saturates at FFFF_FFFF.
//   other offsets: read 0, writes ignored (not an error).
//  Timer: at each edge where CYCLE (pre-increment) == CMP (pre-write), STATUS[0] set.
//   Set and W1C clear in the same cycle: set wins. Same for misalign set vs clear.
//   CMP write in cycle N: compare in cycle N still uses old CMP.
//  Reset (rst=0, async): CYCLE=0, GPIO=0, CMP=FFFF_FFFF, STATUS=0, WCOUNT=0; irq=0,
//   misalign_err=0, gpio_out=0 immediately. RAM contents NOT reset (retain across reset).
//   dmem_rdata during reset: RAM reads still valid; MMIO reads return reset values.
//   Reset asserted mid-write: that write is dropped.
//  irq and misalign_err are registered outputs (equal to STATUS bits), no combinational path.
// TESTING
//  1 Write 0xDEAD_BEEF @0x40, read @0x40 next cycle -> 0xDEAD_BEEF; WCOUNT=1; same-cycle read old.
//  2 we=1 @0x42 data 0x1234 -> RAM @0x40 unchanged, misalign_err=1; W1C 0x2 to STATUS -> 0.
//  3 After reset release, read CYCLE at cycle 10 -> 10; write CYCLE=0x55 -> ignored, counting continues.
//  4 CMP=20 -> irq=1 after edge at CYCLE==20; STATUS W1C 0x1 during CYCLE==20 w/ CMP=20 -> stays 1.
//  5 Write 0x0000_00A5 to GPIO -> gpio_out=0xA5 next edge; assert rst mid-run -> gpio_out=0,
//    CYCLE=0, CMP=FFFF_FFFF at once; RAM @0x40 still 0xDEAD_BEEF after release.
//  6 Address 0x400 with ADDR_W=8 aliases to 0x0; read of MMIO offset 0x20 -> 0.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder for the core's dmem port: word-addressed RAM plus an MMIO block
// (cycle counter, GPIO, timer compare/interrupt, RAM write counter, misaligned-write flag).
module dmem_responder #(
  parameter int unsigned ADDR_W    = 8,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmem_we,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic [31:0] gpio_out,
  output logic        irq,
  output logic        misalign_err
);

  localparam int unsigned DEPTH      = 2 ** ADDR_W;
  localparam logic [29:0] OFF_CYCLE  = 30'd0;
  localparam logic [29:0] OFF_GPIO   = 30'd1;
  localparam logic [29:0] OFF_CMP    = 30'd2;
  localparam logic [29:0] OFF_STATUS = 30'd3;
  localparam logic [29:0] OFF_WCOUNT = 30'd4;

  logic [31:0] mem [DEPTH];

  logic [31:0]       cycle_q;
  logic [31:0]       gpio_q;
  logic [31:0]       cmp_q;
  logic [31:0]       wcount_q;
  logic              irq_q;
  logic              mis_q;

  logic              is_mmio;
  logic              aligned;
  logic              wr_ok;
  logic              ram_wr;
  logic              gpio_wr;
  logic              cmp_wr;
  logic              status_wr;
  logic [29:0]       woff;
  logic [ADDR_W-1:0] idx;

  // Address decode; the word offset drops the byte lane so reads ignore addr[1:0]
  assign is_mmio   = (dmem_addr >= MMIO_BASE);
  assign woff      = 30'((dmem_addr - MMIO_BASE) >> 2);
  assign idx       = dmem_addr[ADDR_W+1:2];
  assign aligned   = (dmem_addr[1:0] == 2'b00);
  assign wr_ok     = dmem_we & aligned;
  assign ram_wr    = wr_ok & ~is_mmio;
  assign gpio_wr   = wr_ok & is_mmio & (woff == OFF_GPIO);
  assign cmp_wr    = wr_ok & is_mmio & (woff == OFF_CMP);
  assign status_wr = wr_ok & is_mmio & (woff == OFF_STATUS);

  // RAM keeps its contents across reset; a write landing while reset is held is dropped
  always_ff @(posedge clk) begin
    if (ram_wr && rst) begin
      mem[idx] <= dmem_wdata;
    end
  end

  // MMIO registers; a status set in the same cycle as its W1C clear wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_q  <= '0;
      gpio_q   <= '0;
      cmp_q    <= 32'hFFFF_FFFF;
      wcount_q <= '0;
      irq_q    <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (gpio_wr) begin
        gpio_q <= dmem_wdata;
      end
      if (cmp_wr) begin
        cmp_q <= dmem_wdata;
      end
      if (ram_wr && (wcount_q != 32'hFFFF_FFFF)) begin
        wcount_q <= wcount_q + 32'd1;
      end
      irq_q <= (cycle_q == cmp_q) | (irq_q & ~(status_wr & dmem_wdata[0]));
      mis_q <= (dmem_we & ~aligned) | (mis_q & ~(status_wr & dmem_wdata[1]));
    end
  end

  assign gpio_out     = gpio_q;
  assign irq          = irq_q;
  assign misalign_err = mis_q;

  // Zero-latency read of pre-edge state
  always_comb begin
    dmem_rdata = '0;
    if (is_mmio) begin
      case (woff)
        OFF_CYCLE:  dmem_rdata = cycle_q;
        OFF_GPIO:   dmem_rdata = gpio_q;
        OFF_CMP:    dmem_rdata = cmp_q;
        OFF_STATUS: dmem_rdata = {30'd0, mis_q, irq_q};
        OFF_WCOUNT: dmem_rdata = wcount_q;
        default:    dmem_rdata = '0;
      endcase
    end else begin
      dmem_rdata = mem[idx];
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed scenarios followed by random traffic,
// checked against a transaction-level memory/register model.
module tb_dmem_responder;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam logic [31:0] BASE   = 32'hFFFF_0000;

  logic        clk;
  logic        rst;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic [31:0] gpio_out;
  logic        irq;
  logic        misalign_err;

  dmem_responder #(.ADDR_W(ADDR_W), .MMIO_BASE(BASE)) dut (
    .clk          (clk),
    .rst          (rst),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .gpio_out     (gpio_out),
    .irq          (irq),
    .misalign_err (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    bit          chk_rd;
    logic [31:0] gpio;
    bit          irq;
    bit          mis;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  // Reference model state
  logic [31:0] m_cycle, m_gpio, m_cmp, m_wcount;
  bit          m_irq, m_mis;
  logic [31:0] m_ram [int];

  task automatic model_reset();
    m_cycle  = 32'd0;
    m_gpio   = 32'd0;
    m_cmp    = 32'hFFFF_FFFF;
    m_wcount = 32'd0;
    m_irq    = 1'b0;
    m_mis    = 1'b0;
  endtask

  // One bus cycle: drive after the edge, queue what the outputs must show, then advance the model
  task automatic step(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                      input bit rn, input string tag);
    exp_t        e;
    logic [31:0] off;
    bit          mm, al, hit;
    int          key;
    @(posedge clk);
    #1;
    dmem_we    = we;
    dmem_addr  = addr;
    dmem_wdata = wd;
    rst        = rn;
    if (!rn) model_reset();
    mm  = (addr >= BASE);
    off = addr - BASE;
    al  = (addr % 4 == 0);
    key = int'((addr / 4) % DEPTH);
    e.chk_rd = 1'b1;
    e.rdata  = 32'd0;
    if (mm) begin
      case (off / 4)
        32'd0:   e.rdata = m_cycle;
        32'd1:   e.rdata = m_gpio;
        32'd2:   e.rdata = m_cmp;
        32'd3:   e.rdata = (m_mis ? 32'd2 : 32'd0) + (m_irq ? 32'd1 : 32'd0);
        32'd4:   e.rdata = m_wcount;
        default: e.rdata = 32'd0;
      endcase
    end else if (m_ram.exists(key)) begin
      e.rdata = m_ram[key];
    end else begin
      e.chk_rd = 1'b0;
    end
    e.gpio = m_gpio;
    e.irq  = m_irq;
    e.mis  = m_mis;
    e.tag  = tag;
    exp_q.push_back(e);
    if (rn) begin
      hit = (m_cycle == m_cmp);
      if (we && !al) begin
        m_mis = 1'b1;
      end else if (we && mm) begin
        if (off == 32'h4) m_gpio = wd;
        if (off == 32'h8) m_cmp = wd;
        if (off == 32'hC) begin
          if (wd[0]) m_irq = 1'b0;
          if (wd[1]) m_mis = 1'b0;
        end
      end else if (we) begin
        m_ram[key] = wd;
        if (m_wcount != 32'hFFFF_FFFF) m_wcount = m_wcount + 32'd1;
      end
      if (hit) m_irq = 1'b1;
      m_cycle = m_cycle + 32'd1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are stable mid-cycle, compare against the oldest queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.chk_rd) chk({e.tag, ".rdata"}, dmem_rdata, e.rdata);
        chk({e.tag, ".gpio"}, gpio_out, e.gpio);
        chk({e.tag, ".irq"}, 32'(irq), 32'(e.irq));
        chk({e.tag, ".misalign"}, 32'(misalign_err), 32'(e.mis));
      end
    end
  end

  initial begin
    logic [31:0] a, wd;
    bit          we;
    int          rhold;
    model_reset();
    rst        = 1'b1;
    dmem_we    = 1'b0;
    dmem_addr  = 32'd0;
    dmem_wdata = 32'd0;
    #2 rst = 1'b0;

    repeat (3) step(0, BASE, 0, 0, "reset");
    // Cycle counter runs from release; writes to it are ignored
    for (int i = 0; i < 12; i++) begin
      if (i == 5) step(1, BASE, 32'h55, 1, "cycle_wr");
      else        step(0, BASE, 0, 1, "cycle_rd");
    end
    step(1, BASE + 32'h8, 32'd20, 1, "cmp_wr");
    while (m_cycle != 32'd20) step(0, BASE + 32'hC, 0, 1, "status_rd");
    step(1, BASE + 32'hC, 32'h1, 1, "w1c_vs_set");
    step(0, BASE + 32'hC, 0, 1, "irq_held");
    step(1, BASE + 32'hC, 32'h1, 1, "irq_clr");
    step(0, BASE + 32'h8, 0, 1, "cmp_rd");

    // RAM write/read, same-cycle read sees old data, WCOUNT
    step(1, 32'h40, 32'h1111_2222, 1, "ram_pre");
    step(1, 32'h40, 32'hDEAD_BEEF, 1, "ram_wr");
    step(0, 32'h43, 0, 1, "ram_rd");
    step(0, BASE + 32'h10, 0, 1, "wcount");
    // Misaligned write suppressed, sticky flag, W1C
    step(1, 32'h42, 32'h1234, 1, "mis_wr");
    step(0, 32'h40, 0, 1, "mis_ram");
    step(1, BASE + 32'hC, 32'h2, 1, "mis_clr");
    step(1, BASE + 32'h6, 32'h0, 1, "mis_mmio");
    step(1, BASE + 32'hC, 32'h3, 1, "mis_clr2");
    // Aliasing and unmapped MMIO
    step(1, 32'h400, 32'hCAFE_0400, 1, "alias_wr");
    step(0, 32'h0, 0, 1, "alias_rd");
    step(1, BASE + 32'h20, 32'hFFFF_FFFF, 1, "unmapped_wr");
    step(0, BASE + 32'h20, 0, 1, "unmapped_rd");
    // GPIO then reset mid-run with a dropped write, RAM retained
    step(1, BASE + 32'h4, 32'h0000_00A5, 1, "gpio_wr");
    step(0, BASE + 32'h4, 0, 1, "gpio_rd");
    step(1, 32'h40, 32'h0BAD_0BAD, 0, "rst_wr");
    step(0, BASE + 32'h8, 0, 0, "rst_cmp");
    step(0, 32'h40, 0, 1, "rel_ram");
    step(0, BASE, 0, 1, "rel_cycle");

    // Random traffic with occasional reset pulses
    rhold = 0;
    for (int i = 0; i < 2500; i++) begin
      case ($urandom_range(0, 3))
        0, 1:    a = 32'($urandom_range(0, 511)) * 32'd4;
        2:       a = BASE + 32'($urandom_range(0, 9)) * 32'd4;
        default: a = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
      we = ($urandom_range(0, 1) == 1);
      wd = (a == BASE + 32'h8) ? m_cycle + 32'($urandom_range(0, 40)) : $urandom;
      if (rhold == 0 && $urandom_range(0, 149) == 0) rhold = $urandom_range(1, 3);
      step(we, a, wd, (rhold == 0), "rand");
      if (rhold > 0) rhold--;
    end
    step(0, 32'h0, 0, 1, "tail");

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
